// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with built-in ALU decoder and memory handshake.
// Optional illegal-opcode trap state enabled by MC_CTRL_ILLEGAL_TRAP_EN.
module mc_ctrl_fsm #(
  parameter int ALUCTL_W = 3,
  parameter bit MEM_HS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                i_or_d,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                alu_src_a,
  output logic                ir_write,
  output logic                mem_write,
  output logic                pc_write,
  output logic                branch,
  output logic                reg_write,
  output logic                ori,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_src_b,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                pc_en,
  output logic                instr_done,
  output logic [3:0]          state_o
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_op
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_ORIEX  = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  state_t state_q, state_d;
  logic   rdy;
  logic   is_r, is_lw, is_sw, is_beq;
  logic   is_addi, is_j, is_ori, is_known;
  logic   unk_done;
  logic [2:0] alu_op;
  logic [2:0] funct_op;

  assign rdy = MEM_HS ? mem_ready : 1'b1;

  assign is_r     = (opcode == OP_R);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_j     = (opcode == OP_J);
  assign is_ori   = (opcode == OP_ORI);
  assign is_known = is_r | is_lw | is_sw | is_beq
                  | is_addi | is_j | is_ori;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEMADR;
          is_r:         state_d = S_EXEC;
          is_beq:       state_d = S_BEQ;
          is_addi:      state_d = S_ADDIEX;
          is_ori:       state_d = S_ORIEX;
          is_j:         state_d = S_JUMP;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        if (is_lw)      state_d = S_MEMRD;
        else if (is_sw) state_d = S_MEMWR;
        else            state_d = S_FETCH;
      end
      S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_ADDIEX: state_d = S_IWB;
      S_ORIEX:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    funct_op = 3'b010;
    unique case (funct)
      6'b100000: funct_op = 3'b010;
      6'b100010: funct_op = 3'b110;
      6'b100100: funct_op = 3'b000;
      6'b100101: funct_op = 3'b001;
      6'b101010: funct_op = 3'b111;
      default:   funct_op = 3'b010;
    endcase
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign unk_done = 1'b0;
`else
  // Unknown opcodes retire as a NOP out of DECODE.
  assign unk_done = ~is_known;
`endif

  always_comb begin
    mem_req    = 1'b0;
    i_or_d     = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    ori        = 1'b0;
    pc_src     = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b010;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        alu_op     = 3'b010;
        instr_done = unk_done;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
      end
      S_MEMRD: begin
        i_or_d  = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        i_or_d     = 1'b1;
        mem_req    = 1'b1;
        mem_write  = rdy;
        instr_done = rdy;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = funct_op;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b110;
        branch     = 1'b1;
        pc_src     = 2'b01;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ori       = 1'b1;
        alu_op    = 3'b001;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset wins over every write-side strobe, even mid-instruction.
    if (rst) begin
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      branch     = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign pc_en       = pc_write | (branch & zero);
  assign alu_control = ALUCTL_W'(alu_op);
  assign state_o     = state_q;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomised self-checking bench for mc_ctrl_fsm.
// Expected behaviour comes from a per-instruction step list model.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, i_or_d, mem_to_reg, reg_dst, alu_src_a;
  logic       ir_write, mem_write, pc_write, branch, reg_write, ori;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_control;
  logic       pc_en, instr_done;
  logic [3:0] state_o;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [5:0] OP_R = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_BAD = 6'b111111;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .ir_write(ir_write),
    .mem_write(mem_write), .pc_write(pc_write), .branch(branch),
    .reg_write(reg_write), .ori(ori), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_en(pc_en), .instr_done(instr_done), .state_o(state_o)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  function automatic logic [2:0] alu_of(int s, logic [5:0] fn);
    if (s == 6) begin
      case (fn)
        6'b100010: return 3'b110;
        6'b100100: return 3'b000;
        6'b100101: return 3'b001;
        6'b101010: return 3'b111;
        default:   return 3'b010;
      endcase
    end
    if (s inside {0, 1, 2, 9}) return 3'b010;
    if (s == 8) return 3'b110;
    if (s == 12) return 3'b001;
    return 3'b000;
  endfunction

  // Build the expected state walk, then replay it cycle by cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm,
                           input string nm);
    int   st[$];
    logic rd[$];
    int   s;
    logic r, last;
    logic e_rw, e_mw, e_pw, e_ir, e_br, e_pcen, e_req;
    logic [1:0] e_pcs;
    for (int k = 0; k < wf; k++) begin st.push_back(0); rd.push_back(0); end
    st.push_back(0); rd.push_back(1);
    st.push_back(1); rd.push_back(1'($urandom));
    if (op == OP_LW) begin
      st.push_back(2); rd.push_back(1'($urandom));
      for (int k = 0; k < wm; k++) begin st.push_back(3); rd.push_back(0); end
      st.push_back(3); rd.push_back(1);
      st.push_back(4); rd.push_back(1'($urandom));
    end else if (op == OP_SW) begin
      st.push_back(2); rd.push_back(1'($urandom));
      for (int k = 0; k < wm; k++) begin st.push_back(5); rd.push_back(0); end
      st.push_back(5); rd.push_back(1);
    end else if (op == OP_R) begin
      st.push_back(6); rd.push_back(1'($urandom));
      st.push_back(7); rd.push_back(1'($urandom));
    end else if (op == OP_BEQ) begin
      st.push_back(8); rd.push_back(1'($urandom));
    end else if (op == OP_ADDI) begin
      st.push_back(9); rd.push_back(1'($urandom));
      st.push_back(10); rd.push_back(1'($urandom));
    end else if (op == OP_ORI) begin
      st.push_back(12); rd.push_back(1'($urandom));
      st.push_back(10); rd.push_back(1'($urandom));
    end else if (op == OP_J) begin
      st.push_back(11); rd.push_back(1'($urandom));
    end
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < st.size(); i++) begin
      s = st[i]; r = rd[i];
      last = (i == st.size() - 1);
      mem_ready = r;
      e_rw = s inside {4, 7, 10};
      e_mw = (s == 5) && r;
      e_pw = ((s == 0) && r) || (s == 11);
      e_ir = (s == 0) && r;
      e_br = (s == 8);
      e_pcen = e_pw || (e_br && z);
      e_req = s inside {0, 3, 5};
      e_pcs = (s == 11) ? 2'b10 : (s == 8) ? 2'b01 : 2'b00;
      @(negedge clk);
      n_chk++;
      if (state_o !== 4'(s)) begin
        n_fail++;
        $display("FAIL %s state c%0d: got %0d exp %0d", nm, i, state_o, s);
      end
      n_chk++;
      if ({reg_write, mem_write, pc_write, ir_write, branch} !==
          {e_rw, e_mw, e_pw, e_ir, e_br}) begin
        n_fail++;
        $display("FAIL %s wen c%0d st%0d: got %b exp %b", nm, i, s,
                 {reg_write, mem_write, pc_write, ir_write, branch},
                 {e_rw, e_mw, e_pw, e_ir, e_br});
      end
      n_chk++;
      if (instr_done !== last) begin
        n_fail++;
        $display("FAIL %s instr_done c%0d: got %b exp %b", nm, i, instr_done, last);
      end
      n_chk++;
      if (pc_en !== e_pcen) begin
        n_fail++;
        $display("FAIL %s pc_en c%0d: got %b exp %b", nm, i, pc_en, e_pcen);
      end
      n_chk++;
      if (alu_control !== alu_of(s, fn)) begin
        n_fail++;
        $display("FAIL %s alu_control c%0d: got %b exp %b", nm, i,
                 alu_control, alu_of(s, fn));
      end
      n_chk++;
      if ({mem_req, ori, pc_src, mem_to_reg, reg_dst} !==
          {e_req, s == 12, e_pcs, s == 4, s == 7}) begin
        n_fail++;
        $display("FAIL %s misc c%0d st%0d: got %b exp %b", nm, i, s,
                 {mem_req, ori, pc_src, mem_to_reg, reg_dst},
                 {e_req, s == 12, e_pcs, s == 4, s == 7});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = OP_LW; funct = '0; zero = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (state_o !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0 ||
          pc_en !== 1'b0 || pc_write !== 1'b0 || ir_write !== 1'b0) begin
        n_fail++;
        $display("FAIL reset c%0d: st=%0d mw=%b rw=%b pcen=%b pw=%b irw=%b", i,
                 state_o, mem_write, reg_write, pc_en, pc_write, ir_write);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_mid_reset();
    opcode = OP_LW; mem_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (state_o !== 4'd4 || reg_write !== 1'b0 || instr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: st=%0d rw=%b done=%b exp st=4 rw=0 done=0",
               state_o, reg_write, instr_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if (state_o !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got %0d exp 0", state_o);
    end
  endtask

  task automatic test_illegal();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    opcode = OP_BAD; mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      n_chk++;
      if (state_o !== 4'd13 || illegal_op !== 1'b1 || reg_write !== 1'b0 ||
          mem_write !== 1'b0 || pc_write !== 1'b0 || instr_done !== 1'b0) begin
        n_fail++;
        $display("FAIL trap c%0d: st=%0d ill=%b rw=%b mw=%b pw=%b", i,
                 state_o, illegal_op, reg_write, mem_write, pc_write);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if (state_o !== 4'd0 || illegal_op !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_exit: st=%0d ill=%b exp 0/0", state_o, illegal_op);
    end
`else
    run_instr(OP_BAD, 6'd0, 1'b0, 0, 0, "illegal_nop");
`endif
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_ORI, OP_BAD};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    for (int n = 0; n < 40; n++) begin
      // Skip the trap-causing opcode here: it never leaves TRAP.
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      run_instr(ops[$urandom_range(0, 6)], fns[$urandom_range(0, 5)],
                1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), "rand");
`else
      run_instr(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 5)],
                1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), "rand");
`endif
    end
  endtask

  initial begin
    test_reset();
    run_instr(OP_LW, 6'd0, 1'b0, 0, 0, "lw");
    run_instr(OP_SW, 6'd0, 1'b0, 0, 3, "sw_wait");
    run_instr(OP_R, 6'b100010, 1'b0, 0, 0, "r_sub");
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0, "beq_taken");
    run_instr(OP_BEQ, 6'd0, 1'b0, 0, 0, "beq_not");
    run_instr(OP_ORI, 6'd0, 1'b0, 0, 0, "ori");
    run_instr(OP_J, 6'd0, 1'b0, 0, 0, "j");
    run_instr(OP_LW, 6'd0, 1'b0, 2, 2, "lw_wait");
    test_back_to_back();
    test_mid_reset();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
